// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared constants for the control-path pipeline.
//   - Control-bundle field layout (LSB first) and the default bundle width.
//   - Stage indices for the default 3-stage build (EX / MEM / WB).
//   - Bubble constant: an all-zero control bundle.
package ctrl_pipe_pkg;

  localparam int CTRL_W = 12;

  // Control bundle layout, LSB first.
  localparam int F_OPC_LSB  = 0;   localparam int F_OPC_W  = 2;
  localparam int F_JMP_LSB  = 2;   localparam int F_JMP_W  = 1;
  localparam int F_BR_LSB   = 3;   localparam int F_BR_W   = 1;
  localparam int F_IMM_LSB  = 4;   localparam int F_IMM_W  = 2;
  localparam int F_ASRC_LSB = 6;   localparam int F_ASRC_W = 1;
  localparam int F_RW_LSB   = 7;   localparam int F_RW_W   = 1;
  localparam int F_MW_LSB   = 8;   localparam int F_MW_W   = 1;
  localparam int F_MR_LSB   = 9;   localparam int F_MR_W   = 1;
  localparam int F_RES_LSB  = 10;  localparam int F_RES_W  = 2;

  localparam int STAGES_DEF = 3;
  localparam int ST_EX      = 0;
  localparam int ST_MEM     = 1;
  localparam int ST_WB      = STAGES_DEF - 1;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  // WB index for a non-default chain length.
  function automatic int st_wb(input int stages);
    return stages - 1;
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one control-pipeline stage register.
//   clk, reset      : clock, asynchronous active-high reset
//   i_hold          : keep current contents (highest priority)
//   i_bubble        : load an all-zero bubble
//   i_valid..i_is_load : incoming bundle; an invalid bundle is stored as a bubble
//   o_*             : registered stage contents (ctrl/regwrite already zero when invalid)
module ctrl_pipe_stage #(
  parameter int CTRL_W = ctrl_pipe_pkg::CTRL_W,
  parameter int RA_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_hold,
  input  logic              i_bubble,
  input  logic              i_valid,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [RA_W-1:0]   i_rd,
  input  logic              i_regwrite,
  input  logic              i_is_load,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [RA_W-1:0]   o_rd,
  output logic              o_regwrite,
  output logic              o_is_load
);
  import ctrl_pipe_pkg::*;

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [RA_W-1:0]   r_rd;
  logic              r_regwrite;
  logic              r_is_load;
  logic              w_kill;

  // Storing invalid slots as bubbles keeps every output clean without gating downstream.
  assign w_kill = i_bubble | ~i_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_is_load  <= 1'b0;
    end else if (!i_hold) begin
      r_valid    <= ~w_kill;
      r_ctrl     <= w_kill ? CTRL_W'(CTRL_BUBBLE) : i_ctrl;
      r_rd       <= w_kill ? '0 : i_rd;
      r_regwrite <= ~w_kill & i_regwrite;
      r_is_load  <= ~w_kill & i_is_load;
    end
  end

  assign o_valid    = r_valid;
  assign o_ctrl     = r_ctrl;
  assign o_rd       = r_rd;
  assign o_regwrite = r_regwrite;
  assign o_is_load  = r_is_load;

endmodule

// File: rtl/ctrl_pipe_n.sv
// ctrl_pipe_n: parametrised control-path pipeline (stage 0 = EX, stage STAGES-1 = WB)
// with RAW / load-use hazard detection, bubble insertion and saturating counters.
//   clk, reset        : clock, asynchronous active-high reset
//   id_*              : decode-slot bundle and register usage
//   ext_stall         : freeze all stages and counters
//   flush             : squash the decode slot (stage 0 takes a bubble)
//   hz_stall          : combinational hold request for IF/ID
//   st_valid/ctrl/rd/regwrite : per-stage contents, stage k in slice k
//   stall_cnt, flush_cnt      : saturating event counters
// Build option: define FWD_EN when the datapath fully bypasses; the hazard window
// then shrinks to a load sitting in stage 0.
module ctrl_pipe_n #(
  parameter int CTRL_W = ctrl_pipe_pkg::CTRL_W,
  parameter int STAGES = 3,
  parameter int RA_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [CTRL_W-1:0]        id_ctrl,
  input  logic [RA_W-1:0]          id_rd,
  input  logic [RA_W-1:0]          id_rs1,
  input  logic [RA_W-1:0]          id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic                     id_regwrite,
  input  logic                     id_is_load,
  input  logic                     ext_stall,
  input  logic                     flush,
  output logic                     hz_stall,
  output logic [STAGES-1:0]        st_valid,
  output logic [STAGES*CTRL_W-1:0] st_ctrl,
  output logic [STAGES*RA_W-1:0]   st_rd,
  output logic [STAGES-1:0]        st_regwrite,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);
  import ctrl_pipe_pkg::*;

  logic [STAGES-1:0]             w_valid, w_rw, w_ld;
  logic [STAGES-1:0][CTRL_W-1:0] w_ctrl;
  logic [STAGES-1:0][RA_W-1:0]   w_rd;

  logic [STAGES-1:0]             w_in_valid, w_in_rw, w_in_ld, w_bub;
  logic [STAGES-1:0][CTRL_W-1:0] w_in_ctrl;
  logic [STAGES-1:0][RA_W-1:0]   w_in_rd;

  logic [STAGES-2:0]             w_match;
  logic                          w_hz_any;
  logic                          w_unused;

  logic [CNT_W-1:0]              r_stall_cnt, r_flush_cnt;

  // Stage 0 is fed from decode, stage k from stage k-1.
  assign w_in_valid = {w_valid[STAGES-2:0], id_valid};
  assign w_in_ctrl  = {w_ctrl[STAGES-2:0],  id_ctrl};
  assign w_in_rd    = {w_rd[STAGES-2:0],    id_rd};
  assign w_in_rw    = {w_rw[STAGES-2:0],    id_regwrite};
  assign w_in_ld    = {w_ld[STAGES-2:0],    id_is_load};
  assign w_bub      = {{(STAGES-1){1'b0}}, flush | hz_stall};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ctrl_pipe_stage #(.CTRL_W(CTRL_W), .RA_W(RA_W)) u_stage (
      .clk        (clk),
      .reset      (reset),
      .i_hold     (ext_stall),
      .i_bubble   (w_bub[k]),
      .i_valid    (w_in_valid[k]),
      .i_ctrl     (w_in_ctrl[k]),
      .i_rd       (w_in_rd[k]),
      .i_regwrite (w_in_rw[k]),
      .i_is_load  (w_in_ld[k]),
      .o_valid    (w_valid[k]),
      .o_ctrl     (w_ctrl[k]),
      .o_rd       (w_rd[k]),
      .o_regwrite (w_rw[k]),
      .o_is_load  (w_ld[k])
    );
  end

  // WB is never compared: the register file writes before it is read.
  for (genvar j = 0; j < STAGES - 1; j++) begin : g_match
    assign w_match[j] = w_valid[j] & w_rw[j] & (w_rd[j] != '0) &
                        ((id_use_rs1 & (id_rs1 == w_rd[j])) |
                         (id_use_rs2 & (id_rs2 == w_rd[j])));
  end

`ifdef FWD_EN
  assign w_hz_any = w_match[ST_EX] & w_ld[ST_EX];
`else
  assign w_hz_any = |w_match;
`endif

  assign hz_stall = id_valid & ~flush & w_hz_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!ext_stall) begin
      if (hz_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush && (r_flush_cnt != '1))    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign st_valid    = w_valid;
  assign st_ctrl     = w_ctrl;
  assign st_rd       = w_rd;
  assign st_regwrite = w_rw;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

  // The WB is_load bit and, with bypassing, the older match terms have no consumer.
  assign w_unused = ^{w_ld[STAGES-1], w_match};

endmodule

// File: tb/tb_ctrl_pipe_n.sv
module tb_ctrl_pipe_n;
  localparam int CW = 12, NS = 3, RW = 4, CN = 16, NSAT = 8;
`ifdef FWD_EN
  localparam int S2 = 1;
  localparam int SAT_BUDGET = 140000;
`else
  localparam int S2 = 2;
  localparam int SAT_BUDGET = 80000;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load, ext_stall, flush;
  logic [CW-1:0] id_ctrl;
  logic [RW-1:0] id_rd, id_rs1, id_rs2;
  logic          hz_stall;
  logic [NS-1:0] st_valid, st_regwrite;
  logic [NS*CW-1:0] st_ctrl;
  logic [NS*RW-1:0] st_rd;
  logic [CN-1:0] stall_cnt, flush_cnt;

  ctrl_pipe_n #(.CTRL_W(CW), .STAGES(NS), .RA_W(RW), .CNT_W(CN)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ext_stall(ext_stall), .flush(flush),
    .hz_stall(hz_stall), .st_valid(st_valid), .st_ctrl(st_ctrl), .st_rd(st_rd),
    .st_regwrite(st_regwrite), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  // Long chain used only to reach counter saturation quickly: the same instruction
  // (writes r1, reads r1) stalls on its predecessor for NSAT-1 cycles out of NSAT.
  logic s_go, s_hz;
  logic [NSAT-1:0] s_st_valid, s_unused_rw;
  logic [NSAT*CW-1:0] s_unused_ctrl;
  logic [NSAT*RW-1:0] s_unused_rd;
  logic [CN-1:0] s_stall_cnt, s_flush_cnt;

  ctrl_pipe_n #(.CTRL_W(CW), .STAGES(NSAT), .RA_W(RW), .CNT_W(CN)) u_sat (
    .clk(clk), .reset(reset), .id_valid(s_go), .id_ctrl(12'h001), .id_rd(4'd1),
    .id_rs1(4'd1), .id_rs2(4'd0), .id_use_rs1(1'b1), .id_use_rs2(1'b0),
    .id_regwrite(1'b1), .id_is_load(1'b1), .ext_stall(1'b0), .flush(1'b0),
    .hz_stall(s_hz), .st_valid(s_st_valid), .st_ctrl(s_unused_ctrl), .st_rd(s_unused_rd),
    .st_regwrite(s_unused_rw), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: list of in-flight instructions ----------------
  typedef struct packed {
    logic          v;
    logic [CW-1:0] c;
    logic [RW-1:0] rd;
    logic          rw;
    logic          ld;
  } ent_t;
  ent_t m [NS];
  int   m_sc, m_fc;

  task automatic model_reset();
    for (int k = 0; k < NS; k++) m[k] = '0;
    m_sc = 0;
    m_fc = 0;
  endtask

  function automatic logic model_hz();
    int   win;
    logic need_ld, h;
`ifdef FWD_EN
    win = 1; need_ld = 1'b1;
`else
    win = NS - 1; need_ld = 1'b0;
`endif
    h = 1'b0;
    for (int j = 0; j < win; j++)
      if (m[j].v && m[j].rw && m[j].rd != 0 && (!need_ld || m[j].ld) &&
          ((id_use_rs1 && id_rs1 == m[j].rd) || (id_use_rs2 && id_rs2 == m[j].rd)))
        h = 1'b1;
    return id_valid && !flush && h;
  endfunction

  task automatic model_clock(input logic h);
    if (!ext_stall) begin
      for (int k = NS - 1; k > 0; k--) m[k] = m[k-1];
      if (flush || h || !id_valid) m[0] = '0;
      else m[0] = '{1'b1, id_ctrl, id_rd, id_regwrite, id_is_load};
      if (h && m_sc < 65535) m_sc++;
      if (flush && m_fc < 65535) m_fc++;
    end
  endtask

  task automatic chk_model();
    logic [NS-1:0] ev, er;
    logic [NS*CW-1:0] ec;
    logic [NS*RW-1:0] ed;
    for (int k = 0; k < NS; k++) begin
      ev[k] = m[k].v;
      er[k] = m[k].rw;
      ec[k*CW +: CW] = m[k].c;
      ed[k*RW +: RW] = m[k].rd;
    end
    chk("model st_valid", 64'(st_valid), 64'(ev));
    chk("model st_ctrl", 64'(st_ctrl), 64'(ec));
    chk("model st_rd", 64'(st_rd), 64'(ed));
    chk("model st_regwrite", 64'(st_regwrite), 64'(er));
    chk("model stall_cnt", 64'(stall_cnt), 64'(m_sc));
    chk("model flush_cnt", 64'(flush_cnt), 64'(m_fc));
  endtask

  // Called with inputs freshly driven, away from any edge.
  task automatic step(output logic hz_seen);
    logic h;
    #1;
    h = model_hz();
    hz_seen = hz_stall;
    chk("model hz_stall", 64'(hz_stall), 64'(h));
    @(posedge clk);
    model_clock(h);
    #1;
    chk_model();
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [RW-1:0] rd,
                       input logic [RW-1:0] rs1, input logic [RW-1:0] rs2, input logic u1,
                       input logic u2, input logic rw, input logic ld, input logic ext,
                       input logic fl);
    id_valid = v; id_ctrl = c; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = rw; id_is_load = ld;
    ext_stall = ext; flush = fl;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " st_valid"}, 64'(st_valid), 64'd0);
    chk({tag, " st_ctrl"}, 64'(st_ctrl), 64'd0);
    chk({tag, " st_rd"}, 64'(st_rd), 64'd0);
    chk({tag, " st_regwrite"}, 64'(st_regwrite), 64'd0);
    chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'd0);
    chk({tag, " flush_cnt"}, 64'(flush_cnt), 64'd0);
    chk({tag, " hz_stall"}, 64'(hz_stall), 64'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic v; logic [CW-1:0] c; logic [RW-1:0] rd, rs1, rs2;
    logic u1, u2, rw, ld, ext, fl;
    logic hz; logic chk_st; logic [NS-1:0] sv; logic [NS*CW-1:0] ectrl; int sc, fc;
  } vec_t;
  localparam int NV = 21;
  vec_t tv [NV];

  initial begin
    logic h;
    int   ns, cyc;
    bit   f1, fsat;

    // one instruction walking the chain
    tv[0]  = '{1, 'h0A5, 3, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 3'b001, 36'h0000000A5, 0, 0};
    tv[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 1, 3'b010, 36'h0000A5000, 0, 0};
    tv[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 1, 3'b100, 36'h0A5000000, 0, 0};
    tv[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 1, 3'b000, 36'h0, 0, 0};
    // load to r5, then a reader of r5
    tv[4]  = '{1, 'h8C1, 5, 0, 0, 0, 0, 1, 1, 0, 0,  0, 1, 3'b001, 36'h0000008C1, 0, 0};
    tv[5]  = '{1, 'h011, 6, 5, 0, 1, 0, 1, 0, 0, 0,  1, 1, 3'b010, 36'h0008C1000, 1, 0};
`ifdef FWD_EN
    tv[6]  = '{1, 'h011, 6, 5, 0, 1, 0, 1, 0, 0, 0,  0, 1, 3'b101, 36'h8C1000011, 1, 0};
    tv[7]  = '{1, 'h011, 6, 5, 0, 1, 0, 1, 0, 0, 0,  0, 1, 3'b011, 36'h000011011, 1, 0};
`else
    tv[6]  = '{1, 'h011, 6, 5, 0, 1, 0, 1, 0, 0, 0,  1, 1, 3'b100, 36'h8C1000000, 2, 0};
    tv[7]  = '{1, 'h011, 6, 5, 0, 1, 0, 1, 0, 0, 0,  0, 1, 3'b001, 36'h000000011, 2, 0};
`endif
    tv[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 3'b000, 36'h0, S2, 0};
    tv[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 3'b000, 36'h0, S2, 0};
    tv[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 1, 3'b000, 36'h0, S2, 0};
    // r0 writer followed by r0 readers: never a hazard
    tv[11] = '{1, 'h123, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 3'b001, 36'h000000123, S2, 0};
    tv[12] = '{1, 'h045, 7, 0, 0, 1, 1, 1, 0, 0, 0,  0, 1, 3'b011, 36'h000123045, S2, 0};
    tv[13] = '{1, 'h046, 8, 0, 0, 1, 0, 1, 0, 0, 0,  0, 1, 3'b111, 36'h123045046, S2, 0};
    // flush together with a RAW on r8
    tv[14] = '{1, 'h077, 9, 8, 0, 1, 0, 1, 0, 0, 1,  0, 1, 3'b110, 36'h045046000, S2, 1};
    // ext_stall with flush held: everything frozen
    for (int i = 15; i <= 18; i++)
      tv[i] = '{1, 'h099, 10, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 3'b110, 36'h045046000, S2, 1};
    tv[19] = '{1, 'h099, 10, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 3'b100, 36'h046000000, S2, 2};
    tv[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 1, 3'b000, 36'h0, S2, 2};

    s_go = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    #11;
    chk_zero("reset");
    chk("reset sat stall_cnt", 64'(s_stall_cnt), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk) #1;

    for (int i = 0; i < NV; i++) begin
      drive(tv[i].v, tv[i].c, tv[i].rd, tv[i].rs1, tv[i].rs2, tv[i].u1, tv[i].u2,
            tv[i].rw, tv[i].ld, tv[i].ext, tv[i].fl);
      step(h);
      chk($sformatf("vec%0d hz_stall", i), 64'(h), 64'(tv[i].hz));
      if (tv[i].chk_st) begin
        chk($sformatf("vec%0d st_valid", i), 64'(st_valid), 64'(tv[i].sv));
        chk($sformatf("vec%0d st_ctrl", i), 64'(st_ctrl), 64'(tv[i].ectrl));
      end
      chk($sformatf("vec%0d stall_cnt", i), 64'(stall_cnt), 64'(tv[i].sc));
      chk($sformatf("vec%0d flush_cnt", i), 64'(flush_cnt), 64'(tv[i].fc));
    end

    // ---------------- randomized traffic against the model ----------------
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), CW'($urandom), RW'($urandom_range(0, 3)),
            RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0));
      step(h);
      if (i == 200) begin
        #2 reset = 1'b1;
        #1 chk_zero("midreset");
        model_reset();
        @(negedge clk) reset = 1'b0;
      end
    end

    // ---------------- counter saturation on the long chain ----------------
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) s_go = 1'b1;
    ns = 0; cyc = 0; f1 = 0; fsat = 0;
    while (ns < 65535 + 20 && cyc < SAT_BUDGET) begin
      @(negedge clk);
      if (s_hz === 1'b1) ns++;
      @(posedge clk) #1;
      cyc++;
      if (ns == 1000 && !f1) begin
        f1 = 1;
        chk("sat stall_cnt at 1000", 64'(s_stall_cnt), 64'd1000);
      end
      if (ns == 65535 && !fsat) begin
        fsat = 1;
        chk("sat stall_cnt reaches max", 64'(s_stall_cnt), 64'hFFFF);
      end
    end
    if (cyc >= SAT_BUDGET) begin
      n_chk++; n_fail++;
      $display("FAIL sat timeout: got %0d stalls, expected %0d", ns, 65535 + 20);
    end
    chk("sat stall_cnt holds at max", 64'(s_stall_cnt), 64'hFFFF);
    chk("sat flush_cnt", 64'(s_flush_cnt), 64'd0);

    #2 reset = 1'b1;
    #1;
    chk("sat reset stall_cnt", 64'(s_stall_cnt), 64'd0);
    chk("sat reset st_valid", 64'(s_st_valid), 64'd0);
    chk("sat reset hz_stall", 64'(s_hz), 64'd0);
    @(negedge clk) reset = 1'b0;
    s_go = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
